// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan driver for an 8-digit seven-segment display.
//
// The block holds a 32-bit value and per-digit blanking controls. It steps
// through the eight digits, spending SCAN_DIV cycles on each one. For the
// current digit it presents that digit's hex nibble to a downstream decoder
// and drives the matching one-hot digit enable. Writes land in a shadow set
// and are committed to the display set only at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Parameters:
//   SCAN_DIV   cycles per digit (>= 2)
//   GUARD      cycles at the start of each digit with all enables off (< SCAN_DIV)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   wr_en        in   one-cycle write strobe (always accepted, no backpressure)
//   wr_data      in   [31:0] value; digit i shows wr_data[4i+3:4i], digit 0 rightmost
//   blank_mask   in   [7:0] bit i = 1 forces digit i off
//   lz_suppress  in   1 = blank leading zero digits
//   nibble       out  [3:0] hex digit at the current scan position
//   seg_en       out  [7:0] active-high one-hot digit enable
//   digit_idx    out  [2:0] current scan position
//   frame_done   out  one-cycle pulse after each frame boundary
module seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  blank_mask,
  input  logic        lz_suppress,
  output logic [3:0]  nibble,
  output logic [7:0]  seg_en,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Scan position
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;

  // Display set (what is on the glass this frame)
  logic [31:0] disp_data_q, disp_data_d;
  logic [7:0]  disp_mask_q, disp_mask_d;
  logic        disp_lz_q, disp_lz_d;

  // Shadow set (waiting for the next frame boundary)
  logic [31:0] sh_data_q, sh_data_d;
  logic [7:0]  sh_mask_q, sh_mask_d;
  logic        sh_lz_q, sh_lz_d;
  logic        pend_q, pend_d;

  logic        frame_done_q, frame_done_d;

  logic        presc_wrap;
  logic        boundary;

  // Output-path helpers
  logic [31:0] upper;
  logic        lz_blank;
  logic        digit_on;

  always_comb begin
    presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
    // The frame boundary is the edge on which digit 7 hands over to digit 0.
    boundary   = presc_wrap && (idx_q == 3'd7);

    presc_d      = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d        = presc_wrap ? idx_q + 3'd1 : idx_q;

    disp_data_d  = disp_data_q;
    disp_mask_d  = disp_mask_q;
    disp_lz_d    = disp_lz_q;
    sh_data_d    = sh_data_q;
    sh_mask_d    = sh_mask_q;
    sh_lz_d      = sh_lz_q;
    pend_d       = pend_q;
    frame_done_d = boundary;

    if (boundary) begin
      // A write arriving on the boundary edge itself is the newest value,
      // so it bypasses the shadow and supersedes anything pending there.
      if (wr_en) begin
        disp_data_d = wr_data;
        disp_mask_d = blank_mask;
        disp_lz_d   = lz_suppress;
      end else if (pend_q) begin
        disp_data_d = sh_data_q;
        disp_mask_d = sh_mask_q;
        disp_lz_d   = sh_lz_q;
      end
      pend_d = 1'b0;
    end else if (wr_en) begin
      sh_data_d = wr_data;
      sh_mask_d = blank_mask;
      sh_lz_d   = lz_suppress;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      disp_data_q  <= 32'd0;
      disp_mask_q  <= 8'd0;
      disp_lz_q    <= 1'b0;
      sh_data_q    <= 32'd0;
      sh_mask_q    <= 8'd0;
      sh_lz_q      <= 1'b0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_mask_q  <= disp_mask_d;
      disp_lz_q    <= disp_lz_d;
      sh_data_q    <= sh_data_d;
      sh_mask_q    <= sh_mask_d;
      sh_lz_q      <= sh_lz_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    // upper holds this digit and everything to its left; zero means the
    // digit is a leading zero. Digit 0 is exempt so a value of 0 shows "0".
    upper      = disp_data_q >> {idx_q, 2'b00};
    nibble     = upper[3:0];
    lz_blank   = disp_lz_q && (idx_q != 3'd0) && (upper == 32'd0);
    digit_on   = !disp_mask_q[idx_q] && !lz_blank;
    seg_en     = (digit_on && (presc_q >= PW'(GUARD))) ? (8'd1 << idx_q) : 8'd0;
    digit_idx  = idx_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with SCAN_DIV = 4, GUARD = 1. A time-based reference
// model computes expected outputs from the cycle count since reset release;
// a compare process checks every cycle, and directed checks pin key values.
module tb_seg_scan;

  localparam int SD = 4;
  localparam int GD = 1;
  localparam int FR = 8 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [7:0]  blank_mask = 8'd0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  nibble;
  logic [7:0]  seg_en;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .blank_mask (blank_mask),
    .lz_suppress(lz_suppress),
    .nibble     (nibble),
    .seg_en     (seg_en),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  // ---------------- reference model ----------------
  int          m_t = 0;          // rising edges since reset release
  logic [31:0] m_disp = 32'd0;
  logic [7:0]  m_mask = 8'd0;
  logic        m_lz = 1'b0;
  logic [31:0] m_sh = 32'd0;
  logic [7:0]  m_shmask = 8'd0;
  logic        m_shlz = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_disp = 0; m_mask = 0; m_lz = 0;
      m_sh = 0; m_shmask = 0; m_shlz = 0; m_pend = 0; m_fd = 0;
    end else begin
      if (m_t % FR == FR - 1) begin
        m_fd = 1'b1;
        if (wr_en) begin
          m_disp = wr_data; m_mask = blank_mask; m_lz = lz_suppress;
        end else if (m_pend) begin
          m_disp = m_sh; m_mask = m_shmask; m_lz = m_shlz;
        end
        m_pend = 1'b0;
      end else begin
        m_fd = 1'b0;
        if (wr_en) begin
          m_sh = wr_data; m_shmask = blank_mask; m_shlz = lz_suppress; m_pend = 1'b1;
        end
      end
      m_t = m_t + 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %h required %h", name, m_t, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    int          e_idx;
    int          e_pre;
    logic [31:0] up;
    logic        on;
    e_idx = (m_t / SD) % 8;
    e_pre = m_t % SD;
    up    = m_disp >> (4 * e_idx);
    on    = !m_mask[e_idx] && !(m_lz && (e_idx > 0) && (up == 32'd0));
    chk("digit_idx", {29'd0, digit_idx}, e_idx);
    chk("nibble", {28'd0, nibble}, {28'd0, up[3:0]});
    chk("seg_en", {24'd0, seg_en}, (on && e_pre >= GD) ? (32'd1 << e_idx) : 32'd0);
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
  end

  // ---------------- driver tasks ----------------
  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (m_t != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (m_t != target) begin
      n_err++;
      $display("FAIL wait_t: reached t=%0d required %0d", m_t, target);
    end
  endtask

  task automatic do_wr(input logic [31:0] d, input logic [7:0] m, input logic lz);
    wr_en = 1'b1; wr_data = d; blank_mask = m; lz_suppress = lz;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // ---------------- hand-computed expectations ----------------
  logic [7:0] exp_seg0 [8] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02};
  logic [3:0] exp_nib2 [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] exp_nib3 [8] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [7:0] exp_seg3 [8] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle: guard cycle then digit 0, then digit 1.
    for (int k = 0; k < 8; k++) begin
      wait_t(k);
      chk("idle_seg", {24'd0, seg_en}, {24'd0, exp_seg0[k]});
      chk("idle_nib", {28'd0, nibble}, 32'd0);
    end
    wait_t(31); chk("fd_before", {31'd0, frame_done}, 32'd0);
    wait_t(32); chk("fd_first", {31'd0, frame_done}, 32'd1);
    wait_t(33); chk("fd_after", {31'd0, frame_done}, 32'd0);

    // Mid-frame write: no change until the boundary.
    wait_t(40); do_wr(32'h1234ABCD, 8'h00, 1'b0);
    wait_t(48); chk("no_tear_nib", {28'd0, nibble}, 32'd0);
    wait_t(64); chk("fd_second", {31'd0, frame_done}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      wait_t(64 + 4 * k + 1);
      chk("abcd_nib", {28'd0, nibble}, {28'd0, exp_nib2[k]});
      chk("abcd_seg", {24'd0, seg_en}, 32'd1 << k);
    end

    // Leading-zero suppression of 0x000000F0.
    wait_t(100); do_wr(32'h000000F0, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_t(128 + 4 * k + 2);
      chk("lz_nib", {28'd0, nibble}, {28'd0, exp_nib3[k]});
      chk("lz_seg", {24'd0, seg_en}, {24'd0, exp_seg3[k]});
    end

    // Zero with suppression shows a single 0; then mask digit 0 too.
    wait_t(170); do_wr(32'h0, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_t(192 + 4 * k + 2);
      chk("zero_seg", {24'd0, seg_en}, (k == 0) ? 32'h01 : 32'h00);
    end
    wait_t(230); do_wr(32'h0, 8'h01, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_t(256 + 4 * k + 2);
      chk("mask_seg", {24'd0, seg_en}, 32'h00);
    end

    // Boundary-edge write supersedes an older pending write.
    wait_t(290); do_wr(32'h9, 8'h00, 1'b0);
    wait_t(319); do_wr(32'h5, 8'h00, 1'b0);
    chk("bnd_fd", {31'd0, frame_done}, 32'd1);
    wait_t(321);
    chk("bnd_nib", {28'd0, nibble}, 32'h5);
    chk("bnd_seg", {24'd0, seg_en}, 32'h01);

    // All-F display, pending second write, then reset mid-frame at digit 5.
    wait_t(330); do_wr(32'hFFFFFFFF, 8'h00, 1'b0);
    wait_t(353); chk("ff_nib", {28'd0, nibble}, 32'hF);
    wait_t(390); do_wr(32'h12345678, 8'h00, 1'b0);
    wait_t(405);
    @(posedge clk);
    #2;
    chk("pre_rst_idx", {29'd0, digit_idx}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_seg", {24'd0, seg_en}, 32'd0);
    chk("rst_nib", {28'd0, nibble}, 32'd0);
    chk("rst_idx", {29'd0, digit_idx}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_t(1);
    chk("post_rst_seg", {24'd0, seg_en}, 32'h01);
    wait_t(32); chk("post_rst_fd", {31'd0, frame_done}, 32'd1);
    wait_t(65); chk("post_rst_nib", {28'd0, nibble}, 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan driver for the 8-digit seven-segment display. It holds a 32-bit value and per-digit blanking controls, then cycles through the eight digits. For each digit it presents that digit's hex nibble to the downstream hex-to-segment decoder and drives the matching one-hot digit enable. New values are double-buffered and take effect only at a frame boundary, so the display never tears.

## Interface
- SCAN_DIV, default 100000: clock cycles spent on each digit (1 ms at 100 MHz); must be ≥ 2.
- GUARD, default 16: cycles at the start of each digit period during which all digit enables are forced off (anti-ghosting); must be < SCAN_DIV.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle strobe; captures wr_data, blank_mask and lz_suppress into the shadow registers.
- wr_data  in  32  value to display; digit i shows wr_data[4i+3:4i], digit 0 is rightmost.
- blank_mask  in  8  bit i = 1 forces digit i off.
- lz_suppress  in  1  1 = blank leading zero digits.
- nibble  out  4  hex digit for the current scan position; goes to the decoder input.
- seg_en  out  8  active-high one-hot digit enable.
- digit_idx  out  3  current scan position.
- frame_done  out  1  one-cycle pulse after each frame boundary.

## Operation
- State:
  - prescaler: 0..SCAN_DIV-1.
  - digit_idx: 0..7.
  - display set: disp_data[31:0], disp_mask[7:0], disp_lz.
  - shadow set: the same three fields plus a pending flag.
- Reset (asynchronous, rst_n low): every register above, including frame_done, is cleared to 0.
- prescaler increments every cycle. At SCAN_DIV-1 it wraps to 0 and digit_idx advances; 7 wraps to 0.
- Frame boundary: the edge where digit_idx wraps from 7 to 0. On that edge, if pending = 1, the shadow set is copied into the display set and pending clears.
- wr_en = 1: the shadow set is loaded from the inputs and pending is set. Back-to-back writes overwrite the shadow set; the last write before a boundary wins.
- wr_en on the frame-boundary edge itself: the input values are written straight into the display set, and pending clears. Any older shadow contents are discarded.
- Leading-zero blanking (disp_lz = 1): digit i is blanked when i > 0 and every nibble from i through 7 of disp_data is zero. Digit 0 is never blanked by this rule, so a value of 0 shows a single "0".
- Per-digit enable: digit_on = ~disp_mask[idx] AND NOT lz-blanked(idx).
- Outputs, combinational from registered state only (no input-to-output paths):
  - nibble = disp_data[4·digit_idx +: 4]. It is valid even when the digit is blanked.
  - seg_en = (1 << digit_idx) when digit_on = 1 and prescaler ≥ GUARD; otherwise seg_en = 8'h00.
- frame_done: registered; high for exactly the one cycle after each frame-boundary edge, whether or not a commit occurred.

## Timing
- Digit period = SCAN_DIV cycles; frame period = 8·SCAN_DIV cycles.
- Write-to-display latency: from 1 cycle (write on the boundary edge) up to 8·SCAN_DIV cycles.
- seg_en is low for GUARD cycles at the start of every digit period, then high for SCAN_DIV-GUARD cycles.
- After reset release:
  - digit_idx = 0, nibble = 0.
  - seg_en = 8'h00 for GUARD cycles, then 8'h01 (disp_lz = 0 and disp_mask = 0 after reset).
- The first frame_done pulse occurs 8·SCAN_DIV cycles after reset release.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). A pending write is lost.
- No handshake: wr_en is always accepted, and there is no backpressure.

## Test plan
All scenarios use SCAN_DIV = 4, GUARD = 1.
- Reset then idle: seg_en = 00 for 1 cycle then 01 for 3 cycles, then 00 followed by 02 for 3 cycles, and so on through 80. nibble = 0 throughout. frame_done pulses every 32 cycles.
- Write 32'h1234ABCD mid-frame: the display is unchanged until the boundary. In the next frame, nibble reads D, C, B, A, 4, 3, 2, 1 for digit_idx 0 through 7.
- Write 32'h0000_00F0 with lz_suppress = 1: only digits 0 and 1 are enabled (nibbles 0 and F). For digits 2–7, seg_en = 00 while nibble still cycles through its values.
- Write 32'h0 with lz_suppress = 1: only digit 0 is lit, showing 0. Then write blank_mask = 8'h01: no digit is ever enabled.
- wr_en on the boundary edge with 32'h5 while an older pending write of 32'h9 exists: the next frame shows 5, and 9 never appears.
- Write 32'hFFFFFFFF, then assert rst_n low at digit_idx = 5 with a second write still pending: outputs go to 0 immediately. After release, the display shows 0 and the pending write never commits.
